fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width per requester.
REQ-002 SHALL have parameter NREQ, default 4, requester count (2..8).
REQ-003 SHALL have parameter DEPTH, default 4, depth of the downstream fifo (power of 2); IDW = $clog2(NREQ), LW = $clog2(DEPTH)+1.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  payload; requester i in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_last  input  NREQ  beat ends requester's packet.
REQ-009 SHALL have port req_ready  output  NREQ  beat accepted this cycle when valid&ready.
REQ-010 SHALL have port fifo_wen  output  1  write strobe to downstream fifo.
REQ-011 SHALL have port fifo_din  output  IDW+WIDTH  {grant id, payload}.
REQ-012 SHALL have port fifo_full  input  1  downstream fifo full.
REQ-013 SHALL have port fifo_rd_en / fifo_empty  input  1 each  downstream read strobe and empty flag (monitored only).
REQ-014 SHALL have port level  output  LW  tracked fifo occupancy.
REQ-015 SHALL have port almost_full  output  1  level >= DEPTH-1.
REQ-016 SHALL have port busy  output  1  high in state LOCK.

Function
REQ-017 SHALL implement states IDLE and LOCK, plus registers last_grant (IDW), lock_id (IDW), level (LW).
REQ-018 In IDLE, grant g SHALL be the first i with req_valid[i]=1, searching last_grant+1, +2, ... modulo NREQ (round robin, wraps).
REQ-019 In LOCK, g SHALL equal lock_id regardless of other requesters' valid.
REQ-020 req_ready[g] SHALL equal !fifo_full (IDLE: only if any valid); all other req_ready bits 0; combinational, zero latency.
REQ-021 fifo_wen SHALL equal req_valid[g] && req_ready[g]; fifo_din = {g, req_data[g]}; fifo_din SHALL be don't-care when fifo_wen=0.
REQ-022 On accepted beat in IDLE: last_grant<=g; if req_last[g]=0 then lock_id<=g, state<=LOCK; else stay IDLE.
REQ-023 On accepted beat in LOCK with req_last[lock_id]=1: state<=IDLE, last_grant<=lock_id; else stay LOCK.
REQ-024 No accepted beat (no valid, fifo_full, or locked requester idle) SHALL change neither state, last_grant nor lock_id.
REQ-025 level SHALL +1 on fifo_wen only, -1 on (fifo_rd_en && !fifo_empty) only, unchanged on both or neither.
REQ-026 level SHALL saturate at DEPTH and at 0 (never wrap).
REQ-027 almost_full SHALL be combinational from registered level; busy = (state==LOCK).

Reset
REQ-028 rst_n=0 at a rising edge SHALL set state=IDLE, last_grant=NREQ-1, lock_id=0, level=0, including mid-packet (packet abandoned).
REQ-029 During and after reset, combinational outputs SHALL follow REQ-018..021 from reset state; requester 0 has first priority.

Verification
REQ-030 Reset, all req_valid=4'b1111, req_last=1111, fifo_full=0 -> fifo_din ids 0,1,2,3,0 on successive cycles, level 1,2,3,4 then held at 4.
REQ-031 Requester 1 sends 3-beat packet (last on beat 3) while requester 2 valid -> ids 1,1,1 then 2; busy high for cycles after beats 1 and 2 only.
REQ-032 fifo_full=1 with req_valid=0001 -> fifo_wen=0, req_ready=0, last_grant unchanged; release full -> id 0 written next cycle.
REQ-033 level=2, fifo_wen and fifo_rd_en (fifo_empty=0) same cycle -> level stays 2; rd_en with fifo_empty=1 -> no decrement.
REQ-034 Reset asserted during LOCK of requester 3 -> next cycle state IDLE, level 0, req_valid=1000 granted as id 3 only after round robin from 0.
REQ-035 last_grant=NREQ-1 with req_valid=1001 -> requester 0 granted (wrap-around).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding a downstream fifo: once a requester wins it keeps
// the grant until its last beat, and the block tracks fifo occupancy from write/read strobes.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    localparam int IDW  = $clog2(NREQ),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wen,
    output logic [IDW+WIDTH-1:0]  fifo_din,
    input  logic                  fifo_full,
    input  logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    output logic [LW-1:0]         level,
    output logic                  almost_full,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state_r;
    logic [IDW-1:0]   last_grant_r;
    logic [IDW-1:0]   lock_id_r;
    logic [LW-1:0]    level_r;

    logic [IDW-1:0]   rr_grant_s;
    logic             rr_any_s;
    logic [IDW-1:0]   sel_s;
    logic             have_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [NREQ-1:0]  ready_s;
    logic             wen_s;
    logic             rd_ok_s;

    // Round-robin search starting just after last_grant; scanning backwards lets the nearest win.
    always_comb begin
        logic [IDW-1:0] idx_v;
        rr_grant_s = '0;
        rr_any_s   = 1'b0;
        idx_v      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx_v      = IDW'((int'(last_grant_r) + k) % NREQ);
            rr_grant_s = req_valid[idx_v] ? idx_v : rr_grant_s;
            rr_any_s   = rr_any_s | req_valid[idx_v];
        end
    end

    // Pick the active requester and route its handshake and payload.
    always_comb begin
        sel_s       = (state_r == ST_LOCK) ? lock_id_r : rr_grant_s;
        have_s      = (state_r == ST_LOCK) | rr_any_s;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        ready_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_valid_s = (sel_s == IDW'(i)) ? req_valid[i] : sel_valid_s;
            sel_last_s  = (sel_s == IDW'(i)) ? req_last[i] : sel_last_s;
            sel_data_s  = (sel_s == IDW'(i)) ? req_data[i*WIDTH +: WIDTH] : sel_data_s;
            ready_s[i]  = have_s & ~fifo_full & (sel_s == IDW'(i));
        end
        wen_s   = sel_valid_s & have_s & ~fifo_full;
        rd_ok_s = fifo_rd_en & ~fifo_empty;
    end

    // Packet-lock state machine and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IDW'(NREQ - 1);
            lock_id_r    <= '0;
        end else if (wen_s) begin
            case (state_r)
                ST_IDLE: begin
                    last_grant_r <= sel_s;
                    if (!sel_last_s) begin
                        lock_id_r <= sel_s;
                        state_r   <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (sel_last_s) begin
                        state_r      <= ST_IDLE;
                        last_grant_r <= lock_id_r;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Occupancy tracker, saturating at both ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_r <= '0;
        end else begin
            case ({wen_s, rd_ok_s})
                2'b10: begin
                    if (level_r < LW'(DEPTH)) begin
                        level_r <= level_r + LW'(1);
                    end
                end
                2'b01: begin
                    if (level_r != LW'(0)) begin
                        level_r <= level_r - LW'(1);
                    end
                end
                default: level_r <= level_r;
            endcase
        end
    end

    assign req_ready   = ready_s;
    assign fifo_wen    = wen_s;
    assign fifo_din    = {sel_s, sel_data_s};
    assign level       = level_r;
    assign almost_full = (level_r >= LW'(DEPTH - 1));
    assign busy        = (state_r == ST_LOCK);

endmodule
